wb_arbiter8: RTL

//  Round-robin arbiter that shares one 32-bit result/write-back channel between 8 requesters.
//  - Drives the 3-bit select of a mux8x32 instance.
//  - Presents the chosen word downstream with a valid/ready handshake.
//  - Returns a one-cycle ack to the winner.
//  - Sits between FPU/ALU/CSR/interrupt sources and the register-file write port.

---
 rtl/wb_arb_pkg.sv | 44 ++++
 rtl/wb_arbiter8_mux8x32.sv | 35 +++
 rtl/wb_arbiter8.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the 8-source write-back arbiter.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package wb_arb_pkg;

  localparam int N_SRC = 8;
  localparam int DW    = 32;
  localparam int SELW  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } pick_t;

  // Round-robin pick: rotate the request vector so that bit 0 is ptr+1,
  // take the lowest set bit, then un-rotate by adding the start back.
  // The 3-bit index arithmetic wraps 7->0 on its own.
  function automatic pick_t rr_pick(input logic [N_SRC-1:0] r,
                                    input logic [SELW-1:0]  ptr);
    logic [SELW-1:0]  start;
    logic [N_SRC-1:0] rot;
    pick_t            res;
    start = ptr + SELW'(1);
    for (int j = 0; j < N_SRC; j++) begin
      rot[j] = r[start + SELW'(j)];
    end
    res.found = 1'b0;
    res.idx   = '0;
    // Descending scan so the lowest rotated position is the last write.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        res.found = 1'b1;
        res.idx   = start + SELW'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_arbiter8_mux8x32.sv
// 8:1 mux of 32-bit words selected by a 3-bit index.
// Latency: purely combinational.
// Backpressure: none; follows s and a0..a7 directly.
module mux8x32
  import wb_arb_pkg::*;
(
  input  logic [DW-1:0]   a0,
  input  logic [DW-1:0]   a1,
  input  logic [DW-1:0]   a2,
  input  logic [DW-1:0]   a3,
  input  logic [DW-1:0]   a4,
  input  logic [DW-1:0]   a5,
  input  logic [DW-1:0]   a6,
  input  logic [DW-1:0]   a7,
  input  logic [SELW-1:0] s,
  output logic [DW-1:0]   y
);

  // Select one of the eight words.
  always_comb begin
    y = a0;
    case (s)
      3'd0: y = a0;
      3'd1: y = a1;
      3'd2: y = a2;
      3'd3: y = a3;
      3'd4: y = a4;
      3'd5: y = a5;
      3'd6: y = a6;
      3'd7: y = a7;
      default: y = a0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter8.sv
// Round-robin arbiter sharing one 32-bit write-back channel between 8 sources.
// Latency: req -> out_valid 1 cycle; back-to-back grants give 1 word per cycle.
// Backpressure: grant frozen while out_ready=0; sticky stall after TIMEOUT waits.
module wb_arbiter8
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [N_SRC-1:0]  req,
  input  logic [DW-1:0]     d0,
  input  logic [DW-1:0]     d1,
  input  logic [DW-1:0]     d2,
  input  logic [DW-1:0]     d3,
  input  logic [DW-1:0]     d4,
  input  logic [DW-1:0]     d5,
  input  logic [DW-1:0]     d6,
  input  logic [DW-1:0]     d7,
  output logic [N_SRC-1:0]  ack,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   sel,
  output logic [N_SRC-1:0]  gnt,
  output logic              stall
);

  state_t            state_q;
  logic [SELW-1:0]   ptr_q;
  logic [SELW-1:0]   sel_q;
  logic [N_SRC-1:0]  gnt_q;
  logic              vld_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic              transfer;
  pick_t             pick_idle;
  pick_t             pick_busy;

  assign transfer  = vld_q & out_ready;
  assign ack       = gnt_q & {N_SRC{transfer}};
  assign out_valid = vld_q;
  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign stall     = stall_q;

  // From IDLE the search starts after the last served source; on a transfer
  // the word just served is masked so the next one can be loaded in the same cycle.
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_busy = rr_pick(req & ~gnt_q, sel_q);

  mux8x32 u_mux (
    .a0 (d0),
    .a1 (d1),
    .a2 (d2),
    .a3 (d3),
    .a4 (d4),
    .a5 (d5),
    .a6 (d6),
    .a7 (d7),
    .s  (sel_q),
    .y  (out_data)
  );

  // Wait counter: counts stalled BUSY cycles, saturates, and latches stall at TIMEOUT.
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (state_q == BUSY && !out_ready) begin
      if (cnt_q != CW'(TIMEOUT)) begin
        cnt_d = cnt_q + CW'(1);
      end
      stall_d = stall_q | (cnt_d == CW'(TIMEOUT));
    end else begin
      cnt_d   = '0;
      stall_d = 1'b0;
    end
  end

  // Grant FSM with registered sel/gnt/out_valid; reset drops any grant without ack.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      sel_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      case (state_q)
        IDLE: begin
          if (pick_idle.found) begin
            sel_q   <= pick_idle.idx;
            gnt_q   <= N_SRC'(1) << pick_idle.idx;
            vld_q   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (transfer) begin
            ptr_q <= sel_q;
            if (pick_busy.found) begin
              sel_q <= pick_busy.idx;
              gnt_q <= N_SRC'(1) << pick_busy.idx;
            end else begin
              gnt_q   <= '0;
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
